// File: rtl/buzzer_pkg.sv
// Shared types and defaults for the buzzer pattern generator.
// Holds the FSM state encoding, default timing constants and the counter width helper.
package buzzer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TONE  = 2'd1,
        GAP   = 2'd2,
        PAUSE = 2'd3
    } state_t;

    localparam int DEF_TONE_HALF = 1;
    localparam int DEF_ON_CYC    = 64;
    localparam int DEF_OFF_CYC   = 64;
    localparam int DEF_PAUSE_CYC = 384;
    localparam int DEF_BURSTS    = 4;

    // Width needed to hold the largest of three terminal values (inclusive).
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/buzzer_tone_div.sv
// Square-wave tone divider: phase toggles every TONE_HALF enabled cycles, starting at 0.
// Registered phase output; clear forces phase and divider count back to 0 on the next edge.
module buzzer_tone_div
    import buzzer_pkg::*;
#(
    parameter int TONE_HALF = DEF_TONE_HALF
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic phase_o
);

    localparam int HW = cnt_width(TONE_HALF, 1, 1);
    localparam logic [HW-1:0] HALF_LAST = HW'(TONE_HALF - 1);

    logic [HW-1:0] half_cnt_q, half_cnt_d;
    logic          phase_q, phase_d;

    always_comb begin
        half_cnt_d = half_cnt_q;
        phase_d    = phase_q;
        if (clr_i) begin
            half_cnt_d = '0;
            phase_d    = 1'b0;
        end else if (en_i) begin
            if (half_cnt_q == HALF_LAST) begin
                half_cnt_d = '0;
                phase_d    = ~phase_q;
            end else begin
                half_cnt_d = half_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            half_cnt_q <= '0;
            phase_q    <= 1'b0;
        end else begin
            half_cnt_q <= half_cnt_d;
            phase_q    <= phase_d;
        end
    end

    assign phase_o = phase_q;

endmodule

// File: rtl/buzzer_pattern_gen.sv
// Alarm buzzer sequencer: BURSTS bursts of (MODE+1) beeps, STOP abort, BUSY/DONE status.
// All outputs registered. Define BUZ_INFINITE_EN to let BURSTS=0 mean repeat until STOP/RST.
module buzzer_pattern_gen
    import buzzer_pkg::*;
#(
    parameter int TONE_HALF = DEF_TONE_HALF,
    parameter int ON_CYC    = DEF_ON_CYC,
    parameter int OFF_CYC   = DEF_OFF_CYC,
    parameter int PAUSE_CYC = DEF_PAUSE_CYC,
    parameter int BURSTS    = DEF_BURSTS
) (
    input  logic       CLK1K,
    input  logic       RST,
    input  logic       ALARM,
    input  logic [1:0] MODE,
    input  logic       STOP,
    output logic       BUZ_OUT,
    output logic       BUSY,
    output logic       DONE
);

    localparam int CW = cnt_width(ON_CYC, OFF_CYC, PAUSE_CYC);
    localparam int BW = cnt_width(BURSTS, 1, 1);

    localparam logic [CW-1:0] ON_LAST    = CW'(ON_CYC - 1);
    localparam logic [CW-1:0] OFF_LAST   = CW'(OFF_CYC - 1);
    localparam logic [CW-1:0] PAUSE_LAST = CW'(PAUSE_CYC - 1);
    localparam logic [BW-1:0] BURST_LAST = BW'((BURSTS > 0) ? BURSTS - 1 : 0);

    if (TONE_HALF < 1 || ON_CYC < 1 || OFF_CYC < 1 || PAUSE_CYC < 1) begin : g_timing_chk
        $error("buzzer_pattern_gen: timing parameters must be >= 1");
    end

`ifdef BUZ_INFINITE_EN
    localparam bit INFINITE = (BURSTS == 0);
`else
    localparam bit INFINITE = 1'b0;
    if (BURSTS < 1) begin : g_bursts_chk
        $error("buzzer_pattern_gen: BURSTS must be >= 1 unless BUZ_INFINITE_EN is defined");
    end
`endif

    state_t        state_q, state_d;
    logic [CW-1:0] cyc_q, cyc_d;
    logic [1:0]    beep_q, beep_d;
    logic [BW-1:0] burst_q, burst_d;
    logic [1:0]    mode_q, mode_d;
    logic          done_q, done_d;
    logic          busy_q;
    logic          tone_clr;
    logic          tone_phase;

    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        beep_d  = beep_q;
        burst_d = burst_q;
        mode_d  = mode_q;
        done_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (ALARM && !STOP) begin
                    state_d = TONE;
                    mode_d  = MODE;
                    cyc_d   = '0;
                    beep_d  = '0;
                    burst_d = '0;
                end
            end
            TONE: begin
                if (cyc_q == ON_LAST) begin
                    cyc_d   = '0;
                    state_d = (beep_q < mode_q) ? GAP : PAUSE;
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end
            GAP: begin
                if (cyc_q == OFF_LAST) begin
                    cyc_d   = '0;
                    beep_d  = beep_q + 2'd1;
                    state_d = TONE;
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end
            PAUSE: begin
                if (cyc_q == PAUSE_LAST) begin
                    cyc_d  = '0;
                    beep_d = '0;
                    if (!INFINITE && (burst_q == BURST_LAST)) begin
                        state_d = IDLE;
                        burst_d = '0;
                        done_d  = 1'b1;
                    end else begin
                        state_d = TONE;
                        // Only reachable in endless mode; hold rather than wrap.
                        if (burst_q != {BW{1'b1}}) begin
                            burst_d = burst_q + 1'b1;
                        end
                    end
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Abort wins over any terminal-count transition, including the final DONE.
        if (STOP && (state_q != IDLE)) begin
            state_d = IDLE;
            cyc_d   = '0;
            beep_d  = '0;
            burst_d = '0;
            done_d  = 1'b0;
        end
    end

    always_ff @(posedge CLK1K) begin
        if (RST) begin
            state_q <= IDLE;
            cyc_q   <= '0;
            beep_q  <= '0;
            burst_q <= '0;
            mode_q  <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            beep_q  <= beep_d;
            burst_q <= burst_d;
            mode_q  <= mode_d;
            done_q  <= done_d;
            busy_q  <= (state_d != IDLE);
        end
    end

    // Phase restarts at 0 on every tone-window entry and is parked at 0 outside windows,
    // so the divider flop can drive the pin directly.
    assign tone_clr = (state_q != TONE) || (state_d != TONE);

    buzzer_tone_div #(
        .TONE_HALF(TONE_HALF)
    ) u_tone_div (
        .clk_i  (CLK1K),
        .rst_i  (RST),
        .clr_i  (tone_clr),
        .en_i   (state_q == TONE),
        .phase_o(tone_phase)
    );

    assign BUZ_OUT = tone_phase;
    assign BUSY    = busy_q;
    assign DONE    = done_q;

endmodule

// File: tb/tb_buzzer_pattern_gen.sv
// Bench for buzzer_pattern_gen: queued expectations per busy episode, checked when BUSY falls.
// Extra directed checks cover reset, gap timing, STOP and a slow-tone instance.
module tb_buzzer_pattern_gen;

    logic       clk;
    logic       rst;
    logic       alarm;
    logic [1:0] mode;
    logic       stop;
    logic       buz;
    logic       busy;
    logic       done;

    logic       alarm2;
    logic [1:0] mode2;
    logic       stop2;
    logic       buz2;
    logic       busy2;
    logic       done2;

    int total = 0;
    int bad   = 0;
    int stray = 0;

    typedef struct {
        int len;
        int rises;
        int done;
    } exp_t;

    exp_t sb_q[$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    buzzer_pattern_gen u_dut (
        .CLK1K  (clk),
        .RST    (rst),
        .ALARM  (alarm),
        .MODE   (mode),
        .STOP   (stop),
        .BUZ_OUT(buz),
        .BUSY   (busy),
        .DONE   (done)
    );

    buzzer_pattern_gen #(
        .TONE_HALF(4),
        .ON_CYC   (64),
        .OFF_CYC  (8),
        .PAUSE_CYC(8),
        .BURSTS   (1)
    ) u_th4 (
        .CLK1K  (clk),
        .RST    (rst),
        .ALARM  (alarm2),
        .MODE   (mode2),
        .STOP   (stop2),
        .BUZ_OUT(buz2),
        .BUSY   (busy2),
        .DONE   (done2)
    );

`ifdef BUZ_INFINITE_EN
    logic alarm3;
    logic stop3;
    logic buz3;
    logic busy3;
    logic done3;

    buzzer_pattern_gen #(
        .TONE_HALF(1),
        .ON_CYC   (4),
        .OFF_CYC  (4),
        .PAUSE_CYC(4),
        .BURSTS   (0)
    ) u_inf (
        .CLK1K  (clk),
        .RST    (rst),
        .ALARM  (alarm3),
        .MODE   (2'd0),
        .STOP   (stop3),
        .BUZ_OUT(buz3),
        .BUSY   (busy3),
        .DONE   (done3)
    );
`endif

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Monitor: one expectation popped per busy episode, at the sample where BUSY falls.
    initial begin
        int   len;
        int   rises;
        logic pb;
        logic pz;
        exp_t e;
        len   = 0;
        rises = 0;
        pb    = 1'b0;
        pz    = 1'b0;
        forever begin
            @(negedge clk);
            if (busy === 1'b1) begin
                len++;
                if (buz === 1'b1 && pz == 1'b0) rises++;
                if (done === 1'b1) stray++;
            end else begin
                if (pb) begin
                    if (sb_q.size() == 0) begin
                        check("sb_unexpected_episode", sb_q.size(), 1);
                    end else begin
                        e = sb_q.pop_front();
                        check("episode_len", len, e.len);
                        check("episode_rises", rises, e.rises);
                        check("done_at_fall", int'(done), e.done);
                    end
                    len   = 0;
                    rises = 0;
                end else if (done === 1'b1) begin
                    stray++;
                end
            end
            pb = (busy === 1'b1);
            pz = (buz === 1'b1);
        end
    end

    task automatic push_exp(input int len, input int rises, input int d);
        exp_t e;
        e.len   = len;
        e.rises = rises;
        e.done  = d;
        sb_q.push_back(e);
    endtask

    // Leaves the caller at the cycle-0 sample point of the new pattern.
    task automatic start_pulse(input logic [1:0] m);
        alarm = 1'b1;
        mode  = m;
        @(negedge clk);
        alarm = 1'b0;
    endtask

    task automatic wait_idle(input int maxc, input string nm);
        int n;
        n = 0;
        while (busy && n < maxc) begin
            @(negedge clk);
            n++;
        end
        check({nm, "_idle_timeout"}, int'(busy), 0);
        @(negedge clk);
    endtask

    initial begin
        int lows;
        int n;
        int first;
        int second;
        int r64;
        int rt;
        logic pz;

        rst    = 1'b1;
        alarm  = 1'b0;
        mode   = 2'd0;
        stop   = 1'b0;
        alarm2 = 1'b0;
        mode2  = 2'd0;
        stop2  = 1'b0;
`ifdef BUZ_INFINITE_EN
        alarm3 = 1'b0;
        stop3  = 1'b0;
`endif
        repeat (3) @(negedge clk);
        check("reset_busy", int'(busy), 0);
        check("reset_buz", int'(buz), 0);
        check("reset_done", int'(done), 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Reset mid-pattern: RST sampled at the edge ending cycle 50.
        push_exp(51, 25, 0);
        start_pulse(2'd0);
        check("start_busy", int'(busy), 1);
        repeat (50) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_busy", int'(busy), 0);
        check("midrst_buz", int'(buz), 0);
        check("midrst_done", int'(done), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check("idle_after_rst", int'(busy), 0);

        // MODE=0: 4 x (64 + 384)
        push_exp(1792, 128, 1);
        start_pulse(2'd0);
        wait_idle(4000, "mode0");

        // MODE=1: 4 x (2*64 + 64 + 384), check the in-burst gap
        push_exp(2304, 256, 1);
        start_pulse(2'd1);
        repeat (63) @(negedge clk);
        check("m1_tone_last_hi", int'(buz), 1);
        lows = 0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (!buz) lows++;
        end
        check("m1_gap_lows", lows, 64);
        @(negedge clk);
        check("m1_tone2_k0", int'(buz), 0);
        @(negedge clk);
        check("m1_tone2_k1", int'(buz), 1);
        wait_idle(4000, "mode1");

        // MODE=3 with MODE change and ALARM pulse mid-run: both ignored
        push_exp(3328, 512, 1);
        start_pulse(2'd3);
        repeat (100) @(negedge clk);
        mode = 2'd0;
        repeat (100) @(negedge clk);
        alarm = 1'b1;
        @(negedge clk);
        alarm = 1'b0;
        wait_idle(5000, "mode3");

        // STOP at cycle 500 of MODE=2 with ALARM held, then restart
        push_exp(501, 96, 0);
        push_exp(2816, 384, 1);
        alarm = 1'b1;
        mode  = 2'd2;
        @(negedge clk);
        repeat (500) @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        check("stop_busy", int'(busy), 0);
        check("stop_buz", int'(buz), 0);
        check("stop_done", int'(done), 0);
        stop = 1'b0;
        @(negedge clk);
        check("restart_busy", int'(busy), 1);
        alarm = 1'b0;
        wait_idle(4000, "restart");

        // STOP in IDLE blocks a start
        stop  = 1'b1;
        alarm = 1'b1;
        repeat (3) @(negedge clk);
        check("stop_blocks_start", int'(busy), 0);
        alarm = 1'b0;
        stop  = 1'b0;
        repeat (2) @(negedge clk);

        // TONE_HALF=4 instance: period 8, 8 rises per 64-cycle beep
        alarm2 = 1'b1;
        mode2  = 2'd1;
        @(negedge clk);
        alarm2 = 1'b0;
        n      = 0;
        first  = -1;
        second = -1;
        r64    = 0;
        rt     = 0;
        pz     = 1'b0;
        while (busy2 && n < 1000) begin
            if (buz2 && !pz) begin
                rt++;
                if (n < 64) r64++;
                if (first < 0) first = n;
                else if (second < 0) second = n;
            end
            pz = buz2;
            n++;
            @(negedge clk);
        end
        check("th4_len", n, 144);
        check("th4_done", int'(done2), 1);
        check("th4_first_rise", first, 4);
        check("th4_period", second - first, 8);
        check("th4_rises_beep", r64, 8);
        check("th4_rises_total", rt, 16);

`ifdef BUZ_INFINITE_EN
        begin
            int dseen;
            dseen  = 0;
            alarm3 = 1'b1;
            @(negedge clk);
            alarm3 = 1'b0;
            for (int i = 0; i < 10000; i++) begin
                @(negedge clk);
                if (done3) dseen++;
            end
            check("inf_busy", int'(busy3), 1);
            check("inf_done_never", dseen, 0);
            stop3 = 1'b1;
            @(negedge clk);
            check("inf_stop", int'(busy3), 0);
            stop3 = 1'b0;
        end
`endif

        repeat (3) @(negedge clk);
        check("sb_drained", sb_q.size(), 0);
        check("stray_done", stray, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
